// File: rtl/mvu_job_scheduler.sv
// Round-robin MVU job scheduler: serializes per-hart job requests onto one MVU.
// Optional `MVU_SCHED_DROP_CNT_EN adds a saturating dropped-start counter.
module mvu_job_scheduler #(
    parameter int NUM_HARTS = 8,
    localparam int HART_W = $clog2(NUM_HARTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_HARTS-1:0]      mvu_start,
    input  logic [2*NUM_HARTS-1:0]    csr_mvu_mul_mode,
    input  logic [29*NUM_HARTS-1:0]   csr_mvu_countdown,
    input  logic [6*NUM_HARTS-1:0]    csr_mvu_wprecision,
    input  logic [6*NUM_HARTS-1:0]    csr_mvu_iprecision,
    input  logic [6*NUM_HARTS-1:0]    csr_mvu_oprecision,
    input  logic [9*NUM_HARTS-1:0]    csr_mvu_wbaseaddr,
    input  logic [15*NUM_HARTS-1:0]   csr_mvu_ibaseaddr,
    input  logic [15*NUM_HARTS-1:0]   csr_mvu_obaseaddr,
`ifdef MVU_SCHED_DROP_CNT_EN
    output logic [15:0]               mvu_drop_cnt,
`endif
    output logic                      mvu_job_start,
    output logic [HART_W-1:0]         mvu_job_hart,
    output logic [1:0]                mvu_mul_mode,
    output logic [28:0]               mvu_countdown,
    output logic [5:0]                mvu_wprecision,
    output logic [5:0]                mvu_iprecision,
    output logic [5:0]                mvu_oprecision,
    output logic [8:0]                mvu_wbaseaddr,
    output logic [14:0]               mvu_ibaseaddr,
    output logic [14:0]               mvu_obaseaddr,
    output logic                      mvu_busy,
    output logic [NUM_HARTS-1:0]      mvu_irq
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_n;
    logic [NUM_HARTS-1:0]  pending, pending_n, clr;
    logic [HART_W-1:0]     last_grant, winner, idx;
    logic                  found, grant;
    logic [28:0]           cnt;
    int                    w;

    // search starts one past the last grant and wraps naturally via HART_W bits
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            idx = last_grant + HART_W'(i + 1);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        unique case (state)
            IDLE: if (found) begin
                grant   = 1'b1;
                state_n = RUN;
            end
            RUN: if (cnt == '0) state_n = DONE;
            DONE: begin
                grant   = found;
                state_n = found ? RUN : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign w         = 32'(winner);
    assign clr       = grant ? (NUM_HARTS'(1) << winner) : '0;
    assign pending_n = (pending & ~clr) | mvu_start;
    assign mvu_busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pending        <= '0;
            last_grant     <= HART_W'(NUM_HARTS - 1);
            cnt            <= '0;
            mvu_job_start  <= 1'b0;
            mvu_job_hart   <= '0;
            mvu_mul_mode   <= '0;
            mvu_countdown  <= '0;
            mvu_wprecision <= '0;
            mvu_iprecision <= '0;
            mvu_oprecision <= '0;
            mvu_wbaseaddr  <= '0;
            mvu_ibaseaddr  <= '0;
            mvu_obaseaddr  <= '0;
            mvu_irq        <= '0;
        end else begin
            state         <= state_n;
            pending       <= pending_n;
            mvu_job_start <= grant;
            // irq reads the old owner, so a same-edge regrant cannot retarget it
            mvu_irq <= (state == DONE) ? (NUM_HARTS'(1) << mvu_job_hart) : '0;
            if (grant) begin
                last_grant     <= winner;
                mvu_job_hart   <= winner;
                cnt            <= csr_mvu_countdown[w*29 +: 29];
                mvu_countdown  <= csr_mvu_countdown[w*29 +: 29];
                mvu_mul_mode   <= csr_mvu_mul_mode[w*2 +: 2];
                mvu_wprecision <= csr_mvu_wprecision[w*6 +: 6];
                mvu_iprecision <= csr_mvu_iprecision[w*6 +: 6];
                mvu_oprecision <= csr_mvu_oprecision[w*6 +: 6];
                mvu_wbaseaddr  <= csr_mvu_wbaseaddr[w*9 +: 9];
                mvu_ibaseaddr  <= csr_mvu_ibaseaddr[w*15 +: 15];
                mvu_obaseaddr  <= csr_mvu_obaseaddr[w*15 +: 15];
            end else if (state == RUN && cnt != '0) begin
                cnt <= cnt - 29'd1;
            end
        end
    end

`ifdef MVU_SCHED_DROP_CNT_EN
    logic [NUM_HARTS-1:0] drop;
    logic [HART_W:0]      ndrop;
    logic [16:0]          drop_sum;

    assign drop = mvu_start & pending & ~clr;

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_HARTS; i++)
            ndrop = ndrop + (HART_W + 1)'(drop[i]);
    end

    assign drop_sum = {1'b0, mvu_drop_cnt} + 17'(ndrop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mvu_drop_cnt <= '0;
        else        mvu_drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
`endif

endmodule

// File: tb/tb_mvu_job_scheduler.sv
// Scoreboard bench for mvu_job_scheduler: expected grants are queued at stimulus
// time and matched against job-start and irq events.
module tb_mvu_job_scheduler;

    localparam int N = 8;
    localparam int HW = 3;

    typedef struct {
        int hart;
        int cnt;
        int wbase;
        int gap;
    } job_t;

    typedef struct {
        logic [N-1:0] vec;
        int           t;
    } irq_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    mvu_start = '0;
    logic [2*N-1:0]  csr_mvu_mul_mode = '0;
    logic [29*N-1:0] csr_mvu_countdown = '0;
    logic [6*N-1:0]  csr_mvu_wprecision = '0;
    logic [6*N-1:0]  csr_mvu_iprecision = '0;
    logic [6*N-1:0]  csr_mvu_oprecision = '0;
    logic [9*N-1:0]  csr_mvu_wbaseaddr = '0;
    logic [15*N-1:0] csr_mvu_ibaseaddr = '0;
    logic [15*N-1:0] csr_mvu_obaseaddr = '0;
    logic            mvu_job_start;
    logic [HW-1:0]   mvu_job_hart;
    logic [1:0]      mvu_mul_mode;
    logic [28:0]     mvu_countdown;
    logic [5:0]      mvu_wprecision, mvu_iprecision, mvu_oprecision;
    logic [8:0]      mvu_wbaseaddr;
    logic [14:0]     mvu_ibaseaddr, mvu_obaseaddr;
    logic            mvu_busy;
    logic [N-1:0]    mvu_irq;
`ifdef MVU_SCHED_DROP_CNT_EN
    logic [15:0]     mvu_drop_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_start = 0;
    job_t exp_q[$];
    irq_t irq_q[$];

    mvu_job_scheduler #(.NUM_HARTS(N)) dut (
        .clk(clk), .rst_n(rst_n), .mvu_start(mvu_start),
        .csr_mvu_mul_mode(csr_mvu_mul_mode),
        .csr_mvu_countdown(csr_mvu_countdown),
        .csr_mvu_wprecision(csr_mvu_wprecision),
        .csr_mvu_iprecision(csr_mvu_iprecision),
        .csr_mvu_oprecision(csr_mvu_oprecision),
        .csr_mvu_wbaseaddr(csr_mvu_wbaseaddr),
        .csr_mvu_ibaseaddr(csr_mvu_ibaseaddr),
        .csr_mvu_obaseaddr(csr_mvu_obaseaddr),
`ifdef MVU_SCHED_DROP_CNT_EN
        .mvu_drop_cnt(mvu_drop_cnt),
`endif
        .mvu_job_start(mvu_job_start), .mvu_job_hart(mvu_job_hart),
        .mvu_mul_mode(mvu_mul_mode), .mvu_countdown(mvu_countdown),
        .mvu_wprecision(mvu_wprecision), .mvu_iprecision(mvu_iprecision),
        .mvu_oprecision(mvu_oprecision), .mvu_wbaseaddr(mvu_wbaseaddr),
        .mvu_ibaseaddr(mvu_ibaseaddr), .mvu_obaseaddr(mvu_obaseaddr),
        .mvu_busy(mvu_busy), .mvu_irq(mvu_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic set_job(input int h, input int c, input int wb);
        csr_mvu_countdown[h*29 +: 29] = 29'(c);
        csr_mvu_wbaseaddr[h*9 +: 9]   = 9'(wb);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [N-1:0] m);
        mvu_start = m;
        cycles(1);
        mvu_start = '0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        do begin
            cycles(1);
            n++;
        end while ((mvu_busy || exp_q.size() != 0 || irq_q.size() != 0)
                   && n < max);
        chk("drain", 32'(exp_q.size() + irq_q.size()) + 32'(mvu_busy), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mvu_job_start) begin
                if (exp_q.size() == 0) begin
                    chk("spur_start", 32'(mvu_job_start), 0);
                end else begin
                    job_t e;
                    irq_t q;
                    e = exp_q.pop_front();
                    chk("job_hart", 32'(mvu_job_hart), e.hart);
                    chk("job_cnt", 32'(mvu_countdown), e.cnt);
                    chk("job_wbase", 32'(mvu_wbaseaddr), e.wbase);
                    chk("job_obase", 32'(mvu_obaseaddr), 32'h100 + e.hart);
                    if (e.gap != 0) chk("job_gap", cyc - last_start, e.gap);
                    q.vec = N'(1) << e.hart;
                    q.t   = cyc + e.cnt + 2;
                    irq_q.push_back(q);
                end
                last_start = cyc;
            end
            if (mvu_irq != '0) begin
                if (irq_q.size() == 0) begin
                    chk("spur_irq", 32'(mvu_irq), 0);
                end else begin
                    irq_t q;
                    q = irq_q.pop_front();
                    chk("irq_vec", 32'(mvu_irq), 32'(q.vec));
                    chk("irq_time", cyc, q.t);
                end
            end
        end
    end

    initial begin
        for (int h = 0; h < N; h++) begin
            csr_mvu_obaseaddr[h*15 +: 15] = 15'(32'h100 + h);
            csr_mvu_mul_mode[h*2 +: 2]    = 2'(h);
        end
        cycles(3);
        chk("rst_busy", 32'(mvu_busy), 0);
        chk("rst_hart", 32'(mvu_job_hart), 0);
        chk("rst_irq", 32'(mvu_irq), 0);
        chk("rst_obase", 32'(mvu_obaseaddr), 0);
        chk("rst_start", 32'(mvu_job_start), 0);
        rst_n = 1'b1;
        cycles(2);

        // round-robin from reset: 0, 2, 5 back-to-back
        for (int h = 0; h < N; h++) set_job(h, 0, 32'h40 + h);
        exp_q.push_back('{0, 0, 32'h40, 0});
        exp_q.push_back('{2, 0, 32'h42, 2});
        exp_q.push_back('{5, 0, 32'h45, 2});
        pulse(8'h25);
        drain(50);

        // single job on hart 3
        set_job(3, 5, 32'h1A5);
        exp_q.push_back('{3, 5, 32'h1A5, 0});
        pulse(8'h08);
        chk("busy_e0", 32'(mvu_busy), 0);
        cycles(1);
        chk("busy_e1", 32'(mvu_busy), 1);
        chk("mul_mode", 32'(mvu_mul_mode), 3);
        drain(50);

        // CSR change during RUN must not affect the job
        set_job(1, 10, 32'h055);
        exp_q.push_back('{1, 10, 32'h055, 0});
        pulse(8'h02);
        cycles(3);
        set_job(1, 2, 32'h0AA);
        cycles(2);
        chk("hold_cnt", 32'(mvu_countdown), 10);
        chk("hold_wbase", 32'(mvu_wbaseaddr), 32'h055);
        drain(50);
        chk("hold_idle", 32'(mvu_countdown), 10);

        // repeated starts on a pending hart are dropped
        set_job(0, 6, 32'h011);
        set_job(4, 1, 32'h044);
        exp_q.push_back('{0, 6, 32'h011, 0});
        exp_q.push_back('{4, 1, 32'h044, 8});
        pulse(8'h01);
        cycles(1);
        for (int k = 0; k < 3; k++) begin
            pulse(8'h10);
            cycles(1);
        end
        drain(50);
`ifdef MVU_SCHED_DROP_CNT_EN
        chk("drop_cnt", 32'(mvu_drop_cnt), 2);
`endif

        // long job, pending harts, then asynchronous reset mid-job
        set_job(0, 20000, 32'h0F0);
        exp_q.push_back('{0, 20000, 32'h0F0, 0});
        pulse(8'h01);
        cycles(2);
        pulse(8'h44);
`ifdef MVU_SCHED_DROP_CNT_EN
        mvu_start = 8'hFE;
        cycles(9500);
        mvu_start = '0;
        cycles(1);
        chk("drop_sat", 32'(mvu_drop_cnt), 32'hFFFF);
`endif
        chk("run_busy", 32'(mvu_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(mvu_busy), 0);
        chk("ar_cnt", 32'(mvu_countdown), 0);
        chk("ar_wbase", 32'(mvu_wbaseaddr), 0);
        chk("ar_obase", 32'(mvu_obaseaddr), 0);
`ifdef MVU_SCHED_DROP_CNT_EN
        chk("ar_drop", 32'(mvu_drop_cnt), 0);
`endif
        irq_q.delete();
        exp_q.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        chk("post_rst_busy", 32'(mvu_busy), 0);

        // start in the same cycle as the grant: two hart-2 jobs
        set_job(2, 1, 32'h122);
        exp_q.push_back('{2, 1, 32'h122, 0});
        exp_q.push_back('{2, 1, 32'h122, 3});
        mvu_start = 8'h04;
        cycles(2);
        mvu_start = '0;
        drain(50);
`ifdef MVU_SCHED_DROP_CNT_EN
        chk("coll_drop", 32'(mvu_drop_cnt), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
